// File: rtl/approx_8x8_seq.sv
// Sequential 8x8 approximate multiplier sharing one approx_4x4 over four steps.
// `APPROX_EXACT_ACCUM_EN selects an exact adder merge instead of the column-OR merge.

module approx_4x4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    // 2x2 block with the classic underdesign: 3*3 yields 7
    function automatic logic [2:0] mul2(input logic [1:0] x, input logic [1:0] w);
        return {x[1] & w[1], (x[1] & w[0]) | (x[0] & w[1]), x[0] & w[0]};
    endfunction

    logic [2:0] p_ll, p_hl, p_lh, p_hh;

    assign p_ll = mul2(a_i[1:0], b_i[1:0]);
    assign p_hl = mul2(a_i[3:2], b_i[1:0]);
    assign p_lh = mul2(a_i[1:0], b_i[3:2]);
    assign p_hh = mul2(a_i[3:2], b_i[3:2]);

    assign p_o = {5'b0, p_ll}
               + {3'b0, p_hl, 2'b0}
               + {3'b0, p_lh, 2'b0}
               + {1'b0, p_hh, 4'b0};
endmodule

module approx_8x8_seq #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] y,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  step_q, step_d;

    logic [3:0]  op_a, op_b;
    logic [7:0]  pp;
    logic [15:0] pp_sh;
    logic [15:0] merged;

    approx_4x4 u_mul (
        .a_i (op_a),
        .b_i (op_b),
        .p_o (pp)
    );

    always_comb begin
        op_a  = a_q[3:0];
        op_b  = b_q[3:0];
        pp_sh = {8'h00, pp};
        unique case (step_q)
            2'd0: begin
                op_a  = a_q[3:0];
                op_b  = b_q[3:0];
                pp_sh = {8'h00, pp};
            end
            2'd1: begin
                op_a  = a_q[7:4];
                op_b  = b_q[3:0];
                pp_sh = {4'h0, pp, 4'h0};
            end
            2'd2: begin
                op_a  = a_q[3:0];
                op_b  = b_q[7:4];
                pp_sh = {4'h0, pp, 4'h0};
            end
            2'd3: begin
                op_a  = a_q[7:4];
                op_b  = b_q[7:4];
                pp_sh = {pp, 8'h00};
            end
            default: ;
        endcase
    end

`ifdef APPROX_EXACT_ACCUM_EN
    assign merged = acc_q + pp_sh;
`else
    assign merged = acc_q | pp_sh;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        step_d  = step_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 16'h0000;
                    step_d  = 2'd0;
                    if (SKIP_ZERO && (a == 8'h00 || b == 8'h00))
                        state_d = DONE;
                    else
                        state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = merged;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = DONE;
                    step_d  = 2'd0;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc_q   <= 16'h0000;
            step_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign y         = acc_q;
endmodule

// File: tb/tb_approx_8x8_seq.sv
// Randomized bench for approx_8x8_seq against an arithmetic model.
// Honours `APPROX_EXACT_ACCUM_EN the same way as the design.

module tb_approx_8x8_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        busy;

    int n_chk;
    int n_pass;

    approx_8x8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int m2(input int x, input int w);
        return (x == 3 && w == 3) ? 7 : x * w;
    endfunction

    function automatic int m4(input int x, input int w);
        return m2(x % 4, w % 4)
             + 4 * m2(x / 4, w % 4)
             + 4 * m2(x % 4, w / 4)
             + 16 * m2(x / 4, w / 4);
    endfunction

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] w);
        int pp [4];
        int r;
        if (x == 0 || w == 0)
            return 16'h0000;
        pp[0] = m4(x % 16, w % 16);
        pp[1] = m4(x / 16, w % 16) * 16;
        pp[2] = m4(x % 16, w / 16) * 16;
        pp[3] = m4(x / 16, w / 16) * 256;
        r = 0;
        for (int i = 0; i < 4; i++) begin
`ifdef APPROX_EXACT_ACCUM_EN
            r = (r + pp[i]) % 65536;
`else
            r = r | pp[i];
`endif
        end
        return r[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation; during back-pressure the next operands are offered.
    task automatic do_mul(input logic [7:0] ta, input logic [7:0] tb,
                          input int hold,
                          input logic [7:0] na, input logic [7:0] nb);
        logic [15:0] exp;
        int cnt;
        int lat;
        exp = ref_mul(ta, tb);
        lat = (ta == 0 || tb == 0) ? 0 : 4;
        chk("acc_rdy", {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("latency", cnt, lat);
        chk("y", {16'b0, y}, {16'b0, exp});
        chk("done_flags", {29'b0, busy, in_ready, out_valid}, 32'b101);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = na;
            b = nb;
            tick();
            chk("hold_y", {16'b0, y}, {16'b0, exp});
            chk("hold_flags", {30'b0, out_valid, in_ready}, 32'b10);
        end
        out_ready = 1'b1;
        tick();
        chk("exit_flags", {29'b0, busy, in_ready, out_valid}, 32'b010);
        chk("exit_y", {16'b0, y}, {16'b0, exp});
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] ca, cb, xa, xb;
        int hold;
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        #3;
        chk("in_reset", {13'b0, in_ready, out_valid, busy, y}, {13'b0, 3'b100, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle", {13'b0, in_ready, out_valid, busy, y}, {13'b0, 3'b100, 16'h0});
        end

        do_mul(8'h12, 8'h21, 0, 8'h00, 8'h00);
        chk("basic", {16'b0, y}, 32'h0252);
        do_mul(8'h11, 8'h11, 0, 8'h00, 8'h00);
`ifdef APPROX_EXACT_ACCUM_EN
        chk("merge", {16'b0, y}, 32'h0121);
`else
        chk("merge", {16'b0, y}, 32'h0111);
`endif
        do_mul(8'h00, 8'hFF, 0, 8'h00, 8'h00);
        chk("skip", {16'b0, y}, 32'h0000);
        do_mul(8'h12, 8'h21, 7, 8'h11, 8'h11);
        chk("bp_held", {16'b0, y}, 32'h0252);
        do_mul(8'h11, 8'h11, 0, 8'h00, 8'h00);

        in_valid = 1'b1;
        a = 8'h34;
        b = 8'h56;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_busy", {31'b0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort", {13'b0, in_ready, out_valid, busy, y}, {13'b0, 3'b100, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_mul(8'h11, 8'h11, 0, 8'h00, 8'h00);
`ifdef APPROX_EXACT_ACCUM_EN
        chk("post_abort", {16'b0, y}, 32'h0121);
`else
        chk("post_abort", {16'b0, y}, 32'h0111);
`endif

        ca = 8'($urandom);
        cb = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            xa = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            xb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if (i % 10 == 0) begin
                xa = 8'hFF;
                xb = 8'hFF;
            end
            hold = $urandom_range(0, 2);
            do_mul(ca, cb, hold, xa, xb);
            ca = xa;
            cb = xb;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
